// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth multiplier: one Booth digit per RUN cycle,
// partial products summed into a 2*WIDTH-bit accumulator.
module booth_pp_accumulator #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned ITERS = WIDTH / 2;
    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    // Multiplicand pre-shifted by 2i so the partial product needs no barrel shift.
    logic [PW-1:0]     mcand_q, mcand_d;
    // {b, 1'b0} shifted right by 2 per iteration; bits [2:0] are the current digit.
    logic [WIDTH:0]    mplr_q, mplr_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     pp;

    // Booth digit decode; all negation is modulo 2^PW, so -2*min is exact.
    always_comb begin
        pp = '0;
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = {{WIDTH{a[WIDTH-1]}}, a};
                    mplr_d  = {b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_q + pp;
                mcand_d = mcand_q << 2;
                mplr_d  = mplr_q >> 2;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                p_d     = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: doc/booth_pp_accumulator.md
BOOTH_PP_ACCUMULATOR -- requirements
Module: booth_pp_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; it SHALL be even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: signed two's-complement multiplicand.
REQ-006 The block SHALL have port b, input, WIDTH bits: signed two's-complement multiplier, the Booth digit source.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking p valid.
REQ-009 The block SHALL have port p, output, 2*WIDTH bits: signed product a*b.

Function
REQ-010 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL register a and b, clear the accumulator and the iteration counter, and enter RUN on the next edge.
REQ-012 In IDLE with start=0, the block SHALL hold all state, and p SHALL keep its last value.
REQ-013 RUN SHALL last exactly WIDTH/2 cycles, one per iteration i = 0 .. WIDTH/2-1.
REQ-014 In iteration i, the block SHALL form the Booth digit from the registered multiplier bits {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0.
REQ-015 The digit decode SHALL be:
  - 000, 111 -> 0
  - 001, 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101, 110 -> -1
REQ-016 In iteration i, the partial product SHALL be digit*a, sign-extended to 2*WIDTH bits and shifted left by 2i; a -2*(-2^(WIDTH-1)) partial product SHALL be exact.
REQ-017 The accumulator SHALL be 2*WIDTH bits and add the partial product modulo 2^(2*WIDTH); the final sum SHALL equal the exact signed product for every operand pair.
REQ-018 After the last iteration, the block SHALL enter DONE, load p with the accumulator and assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency: with start sampled at edge T, done SHALL be high in the cycle after edge T+WIDTH/2+1 (cycle T+5 for WIDTH=8), and p SHALL be valid in the same cycle.
REQ-020 busy SHALL be 1 exactly in RUN cycles and 0 in IDLE and DONE.
REQ-021 start asserted in RUN or DONE SHALL be ignored: no restart, no queuing, and the operands in progress are unaffected.
REQ-022 Changes on a and b after start is accepted SHALL NOT affect the result.
REQ-023 Back-to-back operation: start asserted in the first IDLE cycle after done SHALL be accepted, giving a minimum issue interval of WIDTH/2+2 cycles.
REQ-024 p SHALL hold its value from DONE until the next DONE; it is not cleared on start.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL go to IDLE and clear busy, done, p, the accumulator and the iteration counter to 0, in any state.
REQ-026 rst SHALL take priority over start in the same cycle; an operation interrupted by reset SHALL produce no done pulse.
REQ-027 After rst deasserts, the first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-028 The bench SHALL cover each of the following directed scenarios (WIDTH=8):
  - Basic multiply: a=0x0D (13), b=0xAA (-86), start one cycle -> busy high 4 cycles, done pulse at T+5, p=0xFBA2 (-1118).
  - Negative corner: a=0x80, b=0x80 -> p=0x4000 (16384).
  - Mixed extremes: a=0x7F, b=0x80 -> p=0xC080 (-16256).
  - Start ignored: a=0x00, b=0x55 -> p=0x0000; then start held high during RUN with a=0x03, b=0x03 -> exactly one done per accepted start, second result p=0x0009 issued back-to-back.
  - Reset mid-operation: rst=1 in the 2nd RUN cycle -> next cycle busy=0, done=0, p=0x0000, and no done pulse follows.
REQ-029 The bench SHALL also run an exhaustive 65536-pair sweep against a*b computed in the testbench, with zero mismatches required.
